// File: rtl/immediate_packer_if.sv
// Request/response bundle for immediate_packer: encode requests in, packed
// instruction fields out through a small FIFO.
interface immediate_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imm;
  logic [2:0]  immSrc;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] inmGen;
  logic        err;
  logic [7:0]  err_cnt;

  modport master (
    output in_valid, imm, immSrc, out_ready,
    input  in_ready, out_valid, inmGen, err, err_cnt
  );

  modport slave (
    input  in_valid, imm, immSrc, out_ready,
    output in_ready, out_valid, inmGen, err, err_cnt
  );
endinterface

// File: rtl/immediate_packer.sv
// Packs a 32-bit immediate into RISC-V instruction bits [31:7] for the selected
// format, flags unencodable values, and queues results in a DEPTH-entry FIFO.
module immediate_packer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  immediate_packer_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_U = 3'b010,
    FMT_B = 3'b011,
    FMT_J = 3'b100
  } fmt_e;

  logic [24:0] w_pack;
  logic        w_bad;
  logic        w_sext_i;
  logic        w_sext_b;
  logic        w_sext_j;
  logic [25:0] w_entry;
  logic [25:0] w_head;
  logic        w_push;
  logic        w_pop;

  logic [25:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_err_cnt;

  // Each format can only hold a sign-extended value of its own field width
  assign w_sext_i = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign w_sext_b = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
  assign w_sext_j = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

  always_comb begin
    w_pack = '0;
    w_bad  = 1'b0;
    case (bus.immSrc)
      FMT_I: begin
        w_pack[24:13] = bus.imm[11:0];
        w_bad         = ~w_sext_i;
      end
      FMT_S: begin
        w_pack[24:18] = bus.imm[11:5];
        w_pack[4:0]   = bus.imm[4:0];
        w_bad         = ~w_sext_i;
      end
      FMT_U: begin
        w_pack[24:5] = bus.imm[31:12];
        w_bad        = |bus.imm[11:0];
      end
      FMT_B: begin
        w_pack[24]    = bus.imm[12];
        w_pack[23:18] = bus.imm[10:5];
        w_pack[4:1]   = bus.imm[4:1];
        w_pack[0]     = bus.imm[11];
        w_bad         = ~w_sext_b | bus.imm[0];
      end
      FMT_J: begin
        w_pack[24]    = bus.imm[20];
        w_pack[23:14] = bus.imm[10:1];
        w_pack[13]    = bus.imm[11];
        w_pack[12:5]  = bus.imm[19:12];
        w_bad         = ~w_sext_j | bus.imm[0];
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign w_entry = w_bad ? {1'b1, 25'h0} : {1'b0, w_pack};

  assign bus.in_ready  = (r_count != L_FULL);
  assign bus.out_valid = (r_count != '0);
  assign w_push        = bus.in_valid & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;

  // Empty FIFO forces the head outputs to zero regardless of stale storage
  assign w_head      = r_mem[r_rptr];
  assign bus.inmGen  = bus.out_valid ? w_head[24:0] : '0;
  assign bus.err     = bus.out_valid & w_head[25];
  assign bus.err_cnt = r_err_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_bad && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end
endmodule
